sram_access_arbiter: RTL and testbench

//  Shares one SRAM_controller between two requesters: port 0 = MEM stage data access, port 1 = instruction/loader path.

---
 rtl/sram_access_arbiter_pkg.sv | 24 ++
 rtl/sram_access_arbiter_rr_arbiter2.sv | 54 +++++
 rtl/sram_access_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_sram_access_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_access_arbiter_pkg.sv
// Shared definitions for the SRAM access arbiter: FSM state encodings,
// arbitration mode selectors and the watchdog counter sizing helper.
package sram_access_arbiter_pkg;

    // Arbiter FSM states (2-bit, kept as plain constants for legacy tools)
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    // Arbitration policies
    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    // Width of the watchdog counter: it must hold the value 'limit', and is
    // never narrower than one bit so a disabled watchdog still elaborates.
    function automatic int cnt_width(input int limit);
        if (limit < 2) begin
            return 1;
        end else begin
            return $clog2(limit + 1);
        end
    endfunction

endpackage

// File: rtl/sram_access_arbiter_rr_arbiter2.sv
// Two-request grant logic with the last-grant history register.
// Round-robin mode hands a tie to the port that was not served last;
// fixed mode always hands a tie to port 0. A lone requester always wins.
module rr_arbiter2
    import sram_access_arbiter_pkg::*;
#(
    parameter int PRIO_MODE = PRIO_RR
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    localparam bit FIXED_PRIO = (PRIO_MODE == PRIO_FIXED);

    logic       last_grant_r;
    logic [1:0] grant_s;

    // Pick this cycle's winner from the live requests and the grant history
    always_comb begin
        grant_s = 2'b00;
        case (req)
            2'b01: grant_s = 2'b01;
            2'b10: grant_s = 2'b10;
            2'b11: begin
                if (FIXED_PRIO) begin
                    grant_s = 2'b01;
                end else if (last_grant_r) begin
                    grant_s = 2'b01;
                end else begin
                    grant_s = 2'b10;
                end
            end
            default: grant_s = 2'b00;
        endcase
    end

    assign grant = grant_s;

    // Record the served port when a grant is committed; reset favours port 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_r <= 1'b1;
        end else if (update && (grant_s != 2'b00)) begin
            last_grant_r <= grant_s[1];
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares one SRAM controller between the MEM-stage data port (port 0) and the
// instruction/loader port (port 1). A granted request is latched and held
// stable on the controller interface until the controller reports ready (or
// the watchdog aborts), then the enables drop for one RELEASE cycle while the
// granted port sees a single done pulse with its read data.
module sram_access_arbiter
    import sram_access_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 63,
    parameter int PRIO_MODE = PRIO_RR
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en0,
    input  logic              wr_en0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic [DATA_W-1:0] rdata0,
    output logic              done0,
    output logic              err0,
    output logic              freeze0,
    input  logic              rd_en1,
    input  logic              wr_en1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata1,
    output logic              done1,
    output logic              err1,
    output logic              freeze1,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              timeout_flag
);

    localparam int              CNT_W     = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam bit              WDOG_EN   = (TIMEOUT != 0);

    logic [1:0]        state_r;
    logic              port_r;      // granted port of the access in flight
    logic              op_wr_r;     // access in flight is a write
    logic              issue_r;     // first ACCESS cycle, controller ready is stale
    logic [CNT_W-1:0]  cnt_r;       // ACCESS cycles elapsed, starting at 1

    logic [1:0]        req_s;
    logic [1:0]        grant_s;
    logic              idle_s;
    logic              sel_rd_s;
    logic              sel_wr_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              complete_s;
    logic              abort_s;

    assign idle_s = (state_r == ST_IDLE);

    rr_arbiter2 #(
        .PRIO_MODE (PRIO_MODE)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_s),
        .update (idle_s),
        .grant  (grant_s)
    );

    // Collapse each port to a request bit and steer the winner's command
    always_comb begin
        req_s = {(rd_en1 | wr_en1), (rd_en0 | wr_en0)};
        if (grant_s[1]) begin
            sel_rd_s    = rd_en1;
            sel_wr_s    = wr_en1;
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
        end else begin
            sel_rd_s    = rd_en0;
            sel_wr_s    = wr_en0;
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
        end
    end

    // Decide whether the access in flight finishes or is aborted this cycle
    always_comb begin
        complete_s = 1'b0;
        abort_s    = 1'b0;
        if (state_r == ST_ACCESS) begin
            if (!issue_r && mem_ready) begin
                complete_s = 1'b1;
            end else if (WDOG_EN && (cnt_r == TIMEOUT_C)) begin
                abort_s = 1'b1;
            end else begin
                complete_s = 1'b0;
                abort_s    = 1'b0;
            end
        end else begin
            complete_s = 1'b0;
            abort_s    = 1'b0;
        end
    end

    // Main FSM: grant, hold the controller command stable, then release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            port_r    <= 1'b0;
            op_wr_r   <= 1'b0;
            issue_r   <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_s != 2'b00) begin
                        state_r   <= ST_ACCESS;
                        port_r    <= grant_s[1];
                        op_wr_r   <= sel_wr_s;
                        issue_r   <= 1'b1;
                        cnt_r     <= CNT_ONE;
                        // a simultaneous read and write request is a write
                        mem_wr_en <= sel_wr_s;
                        mem_rd_en <= sel_rd_s & ~sel_wr_s;
                        mem_addr  <= sel_addr_s;
                        mem_wdata <= sel_wdata_s;
                    end else begin
                        state_r   <= ST_IDLE;
                        mem_rd_en <= 1'b0;
                        mem_wr_en <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    issue_r <= 1'b0;
                    if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                    if (complete_s || abort_s) begin
                        state_r   <= ST_RELEASE;
                        mem_rd_en <= 1'b0;
                        mem_wr_en <= 1'b0;
                    end else begin
                        state_r   <= ST_ACCESS;
                    end
                end
                ST_RELEASE: begin
                    state_r   <= ST_IDLE;
                    mem_rd_en <= 1'b0;
                    mem_wr_en <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    issue_r   <= 1'b0;
                    mem_rd_en <= 1'b0;
                    mem_wr_en <= 1'b0;
                end
            endcase
        end
    end

    // Per-port completion pulses, read data capture and the sticky abort flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done0        <= 1'b0;
            done1        <= 1'b0;
            err0         <= 1'b0;
            err1         <= 1'b0;
            rdata0       <= {DATA_W{1'b0}};
            rdata1       <= {DATA_W{1'b0}};
            timeout_flag <= 1'b0;
        end else begin
            done0 <= (complete_s | abort_s) & ~port_r;
            done1 <= (complete_s | abort_s) &  port_r;
            err0  <= abort_s & ~port_r;
            err1  <= abort_s &  port_r;

            if (abort_s) begin
                timeout_flag <= 1'b1;
            end else begin
                timeout_flag <= timeout_flag;
            end

            if (abort_s && !port_r) begin
                rdata0 <= {DATA_W{1'b0}};
            end else if (complete_s && !port_r && !op_wr_r) begin
                rdata0 <= mem_rdata;
            end else begin
                rdata0 <= rdata0;
            end

            if (abort_s && port_r) begin
                rdata1 <= {DATA_W{1'b0}};
            end else if (complete_s && port_r && !op_wr_r) begin
                rdata1 <= mem_rdata;
            end else begin
                rdata1 <= rdata1;
            end
        end
    end

    // Stall each requester from request until its own done pulse
    assign freeze0 = (rd_en0 | wr_en0) & ~done0;
    assign freeze1 = (rd_en1 | wr_en1) & ~done1;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Scoreboard bench for sram_access_arbiter: directed requests push their
// expected completions, a monitor pops and compares on every done pulse.
module tb_sram_access_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rd_en [2];
    logic        wr_en [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
    logic        done0, done1, err0, err1, freeze0, freeze1;
    logic        mem_rd_en, mem_wr_en, mem_ready, timeout_flag;

    logic        fp_rd_en0, fp_rd_en1;
    logic [31:0] fp_rdata0, fp_rdata1, fp_mem_addr, fp_mem_wdata, fp_mem_rdata;
    logic        fp_done0, fp_done1, fp_err0, fp_err1, fp_freeze0, fp_freeze1;
    logic        fp_mem_rd_en, fp_mem_wr_en, fp_mem_ready, fp_timeout_flag;

    int checks = 0;
    int errors = 0;

    typedef struct { int port; logic [31:0] rdata; logic err; } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    logic        stall = 1'b0;
    logic        mem_loaded = 1'b0;
    logic [31:0] mem [16];
    int          m0_cnt = 0;
    int          m1_cnt = 0;

    sram_access_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .PRIO_MODE(0)) dut (
        .clk(clk), .rst(rst),
        .rd_en0(rd_en[0]), .wr_en0(wr_en[0]), .addr0(addr[0]), .wdata0(wdata[0]),
        .rdata0(rdata0), .done0(done0), .err0(err0), .freeze0(freeze0),
        .rd_en1(rd_en[1]), .wr_en1(wr_en[1]), .addr1(addr[1]), .wdata1(wdata[1]),
        .rdata1(rdata1), .done1(done1), .err1(err1), .freeze1(freeze1),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .timeout_flag(timeout_flag)
    );

    sram_access_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0), .PRIO_MODE(1)) dut_fp (
        .clk(clk), .rst(rst),
        .rd_en0(fp_rd_en0), .wr_en0(1'b0), .addr0(32'h0000_0408), .wdata0(32'h0),
        .rdata0(fp_rdata0), .done0(fp_done0), .err0(fp_err0), .freeze0(fp_freeze0),
        .rd_en1(fp_rd_en1), .wr_en1(1'b0), .addr1(32'h0000_040C), .wdata1(32'h0),
        .rdata1(fp_rdata1), .done1(fp_done1), .err1(fp_err1), .freeze1(fp_freeze1),
        .mem_rd_en(fp_mem_rd_en), .mem_wr_en(fp_mem_wr_en), .mem_addr(fp_mem_addr),
        .mem_wdata(fp_mem_wdata), .mem_ready(fp_mem_ready), .mem_rdata(fp_mem_rdata),
        .timeout_flag(fp_timeout_flag)
    );

    // Controller models: ready low while enabled until 2 cycles after enable
    always @(posedge clk) begin
        if (!(mem_rd_en || mem_wr_en)) m0_cnt <= 0;
        else m0_cnt <= m0_cnt + 1;
        if (!(fp_mem_rd_en || fp_mem_wr_en)) m1_cnt <= 0;
        else m1_cnt <= m1_cnt + 1;
    end
    assign mem_ready    = !(mem_rd_en || mem_wr_en) || (!stall && m0_cnt >= 2);
    assign fp_mem_ready = !(fp_mem_rd_en || fp_mem_wr_en) || (m1_cnt >= 2);
    assign mem_rdata    = mem[mem_addr[5:2]];
    assign fp_mem_rdata = mem[fp_mem_addr[5:2]];

    // Shared backing store: preload, then accept completed writes
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hC0DE_0000 | i;
            mem[0] <= 32'hDEAD_BEEF;
            mem_loaded <= 1'b1;
        end else if (mem_wr_en && mem_ready) begin
            mem[mem_addr[5:2]] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push(input int p, input logic [31:0] d, input logic e);
        exp_t x;
        x.port = p; x.rdata = d; x.err = e;
        sb.push_back(x);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (done0 || done1) begin
            if (done0 && done1) begin
                chk("single_done", {30'h0, done1, done0}, 32'h1);
            end else if (sb.size() == 0) begin
                chk("unexpected_done", {31'h0, done1}, 32'hFFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                chk("done_port", done1 ? 32'd1 : 32'd0, mon_e.port);
                chk("done_rdata", done1 ? rdata1 : rdata0, mon_e.rdata);
                chk("done_err", {31'h0, done1 ? err1 : err0}, {31'h0, mon_e.err});
            end
        end
    end

    // Issue one request on port p (called at posedge+1), hold it until done
    task automatic do_req(input int p, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        rd_en[p] = rd; wr_en[p] = wr; addr[p] = a; wdata[p] = d;
        @(negedge clk);
        while (!((p == 0) ? done0 : done1) && n < 60) begin
            n++;
            @(negedge clk);
        end
        chk("req_done_seen", {31'h0, (p == 0) ? done0 : done1}, 32'h1);
        @(posedge clk); #1;
        rd_en[p] = 1'b0; wr_en[p] = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", sb.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int k;
        int c0;
        int c1;
        rst = 1'b0;
        for (int p = 0; p < 2; p++) begin
            rd_en[p] = 1'b0; wr_en[p] = 1'b0; addr[p] = 32'h0; wdata[p] = 32'h0;
        end
        fp_rd_en0 = 1'b0; fp_rd_en1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done_err", {28'h0, done0, done1, err0, err1}, 32'h0);
        chk("rst_freeze", {30'h0, freeze0, freeze1}, 32'h0);
        chk("rst_mem_en", {30'h0, mem_rd_en, mem_wr_en}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_rdata0", rdata0, 32'h0);
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_timeout_flag", {31'h0, timeout_flag}, 32'h0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Port 0 read of 0x400: done at cycle 4, frozen cycles 0-3
        push(0, 32'hDEAD_BEEF, 1'b0);
        rd_en[0] = 1'b1; addr[0] = 32'h0000_0400;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t1_freeze0", {31'h0, freeze0}, (i < 4) ? 32'h1 : 32'h0);
            chk("t1_done0", {31'h0, done0}, (i == 4) ? 32'h1 : 32'h0);
        end
        @(posedge clk); #1;
        rd_en[0] = 1'b0;
        wait_drain();

        // Tie from reset: port 0 write first, port 1 read done at cycle 9
        do_reset();
        push(0, 32'h0000_0000, 1'b0);
        push(1, 32'hDEAD_BEEF, 1'b0);
        fork
            do_req(0, 1'b0, 1'b1, 32'h0000_0404, 32'h1111_2222);
            begin
                rd_en[1] = 1'b1; addr[1] = 32'h0000_0400;
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    chk("t2_freeze1", {31'h0, freeze1}, (i < 9) ? 32'h1 : 32'h0);
                    chk("t2_done1", {31'h0, done1}, (i == 9) ? 32'h1 : 32'h0);
                end
                @(posedge clk); #1;
                rd_en[1] = 1'b0;
            end
        join
        wait_drain();

        // Both ports request continuously: grants alternate 0,1,0,1,...
        do_reset();
        push(0, 32'hC0DE_0002, 1'b0); push(1, 32'h1111_2222, 1'b0);
        push(0, 32'hC0DE_0003, 1'b0); push(1, 32'hC0DE_0006, 1'b0);
        push(0, 32'hC0DE_0004, 1'b0); push(1, 32'hC0DE_0007, 1'b0);
        push(0, 32'hC0DE_0005, 1'b0); push(1, 32'hC0DE_0008, 1'b0);
        fork
            begin
                do_req(0, 1'b1, 1'b0, 32'h0000_0408, 32'h0);
                do_req(0, 1'b1, 1'b0, 32'h0000_040C, 32'h0);
                do_req(0, 1'b1, 1'b0, 32'h0000_0410, 32'h0);
                do_req(0, 1'b1, 1'b0, 32'h0000_0414, 32'h0);
            end
            begin
                do_req(1, 1'b1, 1'b0, 32'h0000_0404, 32'h0);
                do_req(1, 1'b1, 1'b0, 32'h0000_0418, 32'h0);
                do_req(1, 1'b1, 1'b0, 32'h0000_041C, 32'h0);
                do_req(1, 1'b1, 1'b0, 32'h0000_0420, 32'h0);
            end
        join
        wait_drain();

        // Fixed priority: port 0 held for 40 cycles starves port 1
        fp_rd_en0 = 1'b1; fp_rd_en1 = 1'b1;
        c0 = 0; c1 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fp_done0) begin
                c0++;
                chk("fp_rdata0", fp_rdata0, 32'hC0DE_0002);
            end
            if (fp_done1) c1++;
        end
        chk("fp_port0_count", c0, 32'd8);
        chk("fp_port1_count", c1, 32'd0);
        chk("fp_freeze1", {31'h0, fp_freeze1}, 32'h1);
        @(posedge clk); #1;
        fp_rd_en0 = 1'b0;
        k = 0;
        @(negedge clk);
        while (!fp_done1 && k < 20) begin
            k++;
            @(negedge clk);
        end
        chk("fp_port1_served", {31'h0, fp_done1}, 32'h1);
        chk("fp_rdata1", fp_rdata1, 32'hC0DE_0003);
        @(posedge clk); #1;
        fp_rd_en1 = 1'b0;

        // Read and write together: only the write is issued, rdata0 unchanged
        push(0, 32'hC0DE_0005, 1'b0);
        fork
            do_req(0, 1'b1, 1'b1, 32'h0000_0424, 32'h5A5A_5A5A);
            begin
                k = 0;
                @(negedge clk);
                while (!mem_wr_en && k < 10) begin
                    k++;
                    @(negedge clk);
                end
                chk("rw_mem_wr_en", {31'h0, mem_wr_en}, 32'h1);
                chk("rw_mem_rd_en", {31'h0, mem_rd_en}, 32'h0);
                chk("rw_mem_addr", mem_addr, 32'h0000_0424);
                chk("rw_mem_wdata", mem_wdata, 32'h5A5A_5A5A);
            end
        join
        push(0, 32'h5A5A_5A5A, 1'b0);
        do_req(0, 1'b1, 1'b0, 32'h0000_0424, 32'h0);
        wait_drain();

        // Controller never ready: abort after 8 ACCESS cycles, done at cycle 9
        stall = 1'b1;
        push(0, 32'h0000_0000, 1'b1);
        rd_en[0] = 1'b1; addr[0] = 32'h0000_0400;
        k = 0;
        @(negedge clk);
        while (!done0 && k < 30) begin
            k++;
            @(negedge clk);
        end
        chk("timeout_latency", k, 32'd9);
        @(posedge clk); #1;
        rd_en[0] = 1'b0;
        stall = 1'b0;
        chk("timeout_flag_set", {31'h0, timeout_flag}, 32'h1);
        push(1, 32'h1111_2222, 1'b0);
        do_req(1, 1'b1, 1'b0, 32'h0000_0404, 32'h0);
        wait_drain();
        chk("timeout_flag_sticky", {31'h0, timeout_flag}, 32'h1);

        // Reset in the middle of an access: enables drop at once, no done
        rd_en[0] = 1'b1; addr[0] = 32'h0000_0400;
        k = 0;
        @(negedge clk);
        while (!mem_rd_en && k < 10) begin
            k++;
            @(negedge clk);
        end
        chk("midrst_access_started", {31'h0, mem_rd_en}, 32'h1);
        #1 rst = 1'b0;
        #1;
        chk("midrst_mem_en", {30'h0, mem_rd_en, mem_wr_en}, 32'h0);
        chk("midrst_done0", {31'h0, done0}, 32'h0);
        chk("midrst_timeout_flag", {31'h0, timeout_flag}, 32'h0);
        chk("midrst_rdata0", rdata0, 32'h0);
        rd_en[0] = 1'b0;
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        push(1, 32'hC0DE_0002, 1'b0);
        do_req(1, 1'b1, 1'b0, 32'h0000_0408, 32'h0);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
